// File: rtl/fetch_redirect_ctrl_pkg.sv
// Shared types for the fetch redirect controller.
//   wp_e          : EX-stage misprediction class reported by the branch unit
//   stage_meta_t  : prediction metadata carried with each pipeline slot
//   RESET_PC_DEF  : default fetch address after reset
//   align_pc()    : forces a PC onto a word boundary
package bp_pkg;

    // The encoding 2'b11 is illegal and is handled like WP_NONE by consumers.
    typedef enum logic [1:0] {
        WP_NONE         = 2'b00,
        WP_FALSE_TAKEN  = 2'b01,
        WP_MISSED_TAKEN = 2'b10
    } wp_e;

    typedef struct packed {
        logic        valid;
        logic        hit;
        logic [31:0] tgt;
    } stage_meta_t;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_redirect_ctrl_if.sv
// Bundle of the BTB-prediction / EX-correction signals seen by the fetch
// redirect controller.
//   slave  : the controller (consumes prediction and EX inputs, drives PC,
//            flushes, redirect and the event counters)
//   master : the surrounding pipeline / bench
interface fetch_redirect_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             stall_i;
    logic             hit_i;
    logic [31:0]      predicted_pc_i;
    logic [1:0]       wrong_predicted_i;
    logic [31:0]      alu_pc_i;
    logic [31:0]      pc_ex_i;
    logic [31:0]      pc_o;
    logic             hit_ex_o;
    logic             flush_if_id_o;
    logic             flush_id_ex_o;
    logic             redirect_o;
    logic [CNT_W-1:0] mispred_cnt_o;
    logic [CNT_W-1:0] pred_taken_cnt_o;

    modport slave (
        input  stall_i, hit_i, predicted_pc_i, wrong_predicted_i, alu_pc_i, pc_ex_i,
        output pc_o, hit_ex_o, flush_if_id_o, flush_id_ex_o, redirect_o,
               mispred_cnt_o, pred_taken_cnt_o
    );

    modport master (
        output stall_i, hit_i, predicted_pc_i, wrong_predicted_i, alu_pc_i, pc_ex_i,
        input  pc_o, hit_ex_o, flush_if_id_o, flush_id_ex_o, redirect_o,
               mispred_cnt_o, pred_taken_cnt_o
    );
endinterface

// File: rtl/fetch_redirect_ctrl_sat_counter.sv
// Saturating event counter: counts up by one per cycle with inc_i high and
// sticks at all-ones.
//   clk_i   : clock
//   clr_ni  : synchronous clear, active low
//   inc_i   : increment request
//   cnt_o   : registered count value
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         clr_ni,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);
    logic [W-1:0] cnt_r;

    // Count register with synchronous clear and saturation at all-ones.
    always_ff @(posedge clk_i) begin
        if (!clr_ni) begin
            cnt_r <= {W{1'b0}};
        end else if (inc_i && (cnt_r != {W{1'b1}})) begin
            cnt_r <= cnt_r + {{(W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt_o = cnt_r;
endmodule

// File: rtl/fetch_redirect_ctrl.sv
// Fetch redirect controller: owns the fetch PC, picks the next PC from
// PC+4, the BTB prediction or an EX correction, carries each slot's
// prediction metadata through IF/ID and ID/EX, and flushes wrong-path
// slots on a misprediction.
//   clk_i   : clock
//   rst_ni  : synchronous reset, active low
//   bus     : fetch_redirect_ctrl_if.slave (BTB prediction in, EX outcome
//             in, fetch PC / hit_ex / flushes / redirect / counters out)
module fetch_redirect_ctrl
    import bp_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int          CNT_W    = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    fetch_redirect_ctrl_if.slave  bus
);
    logic [31:0] pc_r;
    logic [31:0] pc_next_s;
    stage_meta_t id_r;
    stage_meta_t ex_r;
    stage_meta_t id_next_s;
    stage_meta_t ex_next_s;
    logic        mispredict_s;
    logic [31:0] redirect_pc_s;
    logic        pred_follow_s;

    // Misprediction detection on the EX slot; nothing is checked for a bubble.
    always_comb begin
        mispredict_s  = 1'b0;
        redirect_pc_s = bus.alu_pc_i;
        if (ex_r.valid) begin
            case (bus.wrong_predicted_i)
                WP_FALSE_TAKEN: begin
                    mispredict_s  = 1'b1;
                    redirect_pc_s = bus.pc_ex_i + 32'd4;
                end
                WP_MISSED_TAKEN: begin
                    mispredict_s  = 1'b1;
                    redirect_pc_s = bus.alu_pc_i;
                end
                // WP_NONE and the illegal 2'b11: a taken prediction whose
                // target disagrees with the resolved one is still a miss.
                default: begin
                    mispredict_s  = ex_r.hit && (bus.alu_pc_i != ex_r.tgt);
                    redirect_pc_s = bus.alu_pc_i;
                end
            endcase
        end else begin
            mispredict_s  = 1'b0;
            redirect_pc_s = bus.alu_pc_i;
        end
    end

    // Next-PC selection and stage metadata advance; a redirect overrides stall.
    always_comb begin
        pc_next_s     = pc_r;
        id_next_s     = id_r;
        ex_next_s     = ex_r;
        pred_follow_s = 1'b0;
        if (mispredict_s) begin
            pc_next_s = align_pc(redirect_pc_s);
            id_next_s = '{valid: 1'b0, hit: 1'b0, tgt: 32'h0000_0000};
            ex_next_s = '{valid: 1'b0, hit: 1'b0, tgt: 32'h0000_0000};
        end else if (bus.stall_i) begin
            pc_next_s = pc_r;
            id_next_s = id_r;
            // Bubble into EX; the target is don't-care once valid is low.
            ex_next_s.valid = 1'b0;
            ex_next_s.hit   = 1'b0;
        end else begin
            if (bus.hit_i) begin
                pc_next_s     = align_pc(bus.predicted_pc_i);
                pred_follow_s = 1'b1;
            end else begin
                pc_next_s     = align_pc(pc_r + 32'd4);
                pred_follow_s = 1'b0;
            end
            id_next_s = '{valid: 1'b1, hit: bus.hit_i, tgt: bus.predicted_pc_i};
            ex_next_s = id_r;
        end
    end

    // PC and stage registers; reset wins over every other event.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pc_r <= RESET_PC;
            id_r <= '{valid: 1'b0, hit: 1'b0, tgt: 32'h0000_0000};
            ex_r <= '{valid: 1'b0, hit: 1'b0, tgt: 32'h0000_0000};
        end else begin
            pc_r <= pc_next_s;
            id_r <= id_next_s;
            ex_r <= ex_next_s;
        end
    end

    sat_counter #(.W(CNT_W)) u_mispred_cnt (
        .clk_i  (clk_i),
        .clr_ni (rst_ni),
        .inc_i  (mispredict_s),
        .cnt_o  (bus.mispred_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_pred_taken_cnt (
        .clk_i  (clk_i),
        .clr_ni (rst_ni),
        .inc_i  (pred_follow_s),
        .cnt_o  (bus.pred_taken_cnt_o)
    );

    assign bus.pc_o          = pc_r;
    assign bus.hit_ex_o      = ex_r.valid & ex_r.hit;
    assign bus.redirect_o    = mispredict_s;
    assign bus.flush_if_id_o = mispredict_s;
    assign bus.flush_id_ex_o = mispredict_s;
endmodule
